// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, NOP constant, default reset PC
// and the PC alignment helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that parks a response
// arriving while the decode stage is stalled.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        push,
    input  logic        pop,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic [31:0] data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    logic        skid_valid_r;
    logic [31:0] skid_data_r;

    // IF/ID and skid update; flush has priority over every other action including stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_valid  <= 1'b0;
            if_id_pc     <= 32'h0000_0000;
            if_id_instr  <= NOP_INSTR;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 32'h0000_0000;
        end else if (flush) begin
            if_id_valid  <= 1'b0;
            if_id_instr  <= NOP_INSTR;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 32'h0000_0000;
        end else if (load) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc;
            if_id_instr <= data;
        end else if (pop) begin
            if_id_valid  <= skid_valid_r;
            if_id_pc     <= pc;
            if_id_instr  <= skid_data_r;
            skid_valid_r <= 1'b0;
        end else if (push) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= data;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register and fetch FSM driving the instruction-memory
// bus, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               stall,
    fetch_stage_if.master      imem,
    output logic               if_id_valid,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_instr
);

    fetch_state_e state_r, state_nx;
    logic [31:0]  pc_r, pc_nx;
    logic         req_valid_s, load_s, push_s, pop_s, flush_s;

    // Next-state, next-pc and IF/ID control decode
    always_comb begin
        state_nx    = state_r;
        pc_nx       = pc_r;
        load_s      = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        flush_s     = redirect_valid;
        req_valid_s = (state_r == ST_FETCH) && !redirect_valid && rst_n;
        if (redirect_valid) begin
            pc_nx = align_pc(redirect_pc);
            // A request still in flight must have its response discarded
            if (((state_r == ST_WAIT) || (state_r == ST_DROP)) && !imem.imem_resp_valid) begin
                state_nx = ST_DROP;
            end else begin
                state_nx = ST_FETCH;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (req_valid_s && imem.imem_req_ready) begin
                        state_nx = ST_WAIT;
                    end else begin
                        state_nx = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_resp_valid && stall) begin
                        push_s   = 1'b1;
                        state_nx = ST_HOLD;
                    end else if (imem.imem_resp_valid) begin
                        load_s   = 1'b1;
                        pc_nx    = pc_r + PC_STEP;
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pop_s    = 1'b1;
                        pc_nx    = pc_r + PC_STEP;
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (imem.imem_resp_valid) begin
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = ST_DROP;
                    end
                end
                default: begin
                    state_nx = ST_FETCH;
                end
            endcase
        end
    end

    // State and pc registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nx;
            pc_r    <= pc_nx;
        end
    end

    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_addr      = pc_r;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush_s),
        .load        (load_s),
        .push        (push_s),
        .pop         (pop_s),
        .stall       (stall),
        .pc          (pc_r),
        .data        (imem.imem_resp_data),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, normal fetch, stall/skid,
// redirect in WAIT with response drop, flush-over-stall, PC alignment and wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem           (imem_bus),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n                    = 1'b0;
        redirect_valid           = 1'b0;
        redirect_pc              = 32'h0000_0000;
        stall                    = 1'b0;
        imem_bus.imem_req_ready  = 1'b0;
        imem_bus.imem_resp_valid = 1'b0;
        imem_bus.imem_resp_data  = 32'h0000_0000;

        // Reset state
        tick();
        tick();
        imem_bus.imem_req_ready = 1'b1;
        settle();
        chk("rst_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        chk("rst_addr", imem_bus.imem_addr, 32'h0000_0000);
        chk("rst_ifid_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_ifid_pc", if_id_pc, 32'h0000_0000);
        chk("rst_ifid_instr", if_id_instr, 32'h0000_0013);

        // First fetch, response one cycle after acceptance
        rst_n = 1'b1;
        settle();
        chk("f1_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd1);
        chk("f1_addr", imem_bus.imem_addr, 32'h0000_0000);
        tick();
        chk("f1_wait_no_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        imem_bus.imem_resp_valid = 1'b1;
        imem_bus.imem_resp_data  = 32'h0050_0093;
        tick();
        imem_bus.imem_resp_valid = 1'b0;
        settle();
        chk("f1_ifid_valid", {31'd0, if_id_valid}, 32'd1);
        chk("f1_ifid_pc", if_id_pc, 32'h0000_0000);
        chk("f1_ifid_instr", if_id_instr, 32'h0050_0093);
        chk("f1_next_addr", imem_bus.imem_addr, 32'h0000_0004);
        chk("f1_next_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);

        // Stall when the response arrives: skid into HOLD for 3 cycles
        tick();
        chk("s_bubble_valid", {31'd0, if_id_valid}, 32'd0);
        stall                    = 1'b1;
        imem_bus.imem_resp_valid = 1'b1;
        imem_bus.imem_resp_data  = 32'h00A0_0113;
        tick();
        imem_bus.imem_resp_valid = 1'b0;
        imem_bus.imem_resp_data  = 32'h0000_0000;
        settle();
        chk("s_hold_valid", {31'd0, if_id_valid}, 32'd0);
        chk("s_hold_instr", if_id_instr, 32'h0050_0093);
        chk("s_hold_no_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        tick();
        tick();
        chk("s_hold3_instr", if_id_instr, 32'h0050_0093);
        chk("s_hold3_no_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        chk("s_hold3_addr", imem_bus.imem_addr, 32'h0000_0004);
        stall = 1'b0;
        tick();
        chk("s_rel_valid", {31'd0, if_id_valid}, 32'd1);
        chk("s_rel_pc", if_id_pc, 32'h0000_0004);
        chk("s_rel_instr", if_id_instr, 32'h00A0_0113);
        chk("s_rel_addr", imem_bus.imem_addr, 32'h0000_0008);
        chk("s_rel_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);

        // Redirect in WAIT together with stall: flush wins, response dropped
        stall = 1'b1;
        tick();
        chk("r_wait_hold_valid", {31'd0, if_id_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        settle();
        chk("r_flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("r_flush_instr", if_id_instr, 32'h0000_0013);
        chk("r_pc", imem_bus.imem_addr, 32'h0000_0100);
        chk("r_drop_no_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        imem_bus.imem_resp_valid = 1'b1;
        imem_bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_resp_valid = 1'b0;
        settle();
        chk("r_dropped_valid", {31'd0, if_id_valid}, 32'd0);
        chk("r_dropped_instr", if_id_instr, 32'h0000_0013);
        chk("r_next_addr", imem_bus.imem_addr, 32'h0000_0100);
        chk("r_next_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);

        // Response while in FETCH (not accepted) is ignored
        imem_bus.imem_req_ready  = 1'b0;
        imem_bus.imem_resp_valid = 1'b1;
        imem_bus.imem_resp_data  = 32'hAAAA_5555;
        tick();
        imem_bus.imem_resp_valid = 1'b0;
        settle();
        chk("ign_valid", {31'd0, if_id_valid}, 32'd0);
        chk("ign_instr", if_id_instr, 32'h0000_0013);
        chk("ign_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);

        // Misaligned redirect target with stall in FETCH
        imem_bus.imem_req_ready = 1'b1;
        redirect_valid          = 1'b1;
        redirect_pc             = 32'h0000_0203;
        stall                   = 1'b1;
        settle();
        chk("al_req_suppressed", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        settle();
        chk("al_addr", imem_bus.imem_addr, 32'h0000_0200);
        chk("al_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_bus.imem_resp_valid = 1'b1;
        imem_bus.imem_resp_data  = 32'h1234_5678;
        tick();
        imem_bus.imem_resp_valid = 1'b0;
        settle();
        chk("wr_ifid_valid", {31'd0, if_id_valid}, 32'd1);
        chk("wr_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wr_ifid_instr", if_id_instr, 32'h1234_5678);
        chk("wr_next_addr", imem_bus.imem_addr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
